// File: rtl/pipelined_control.sv
// Pipelined LEGv8 control unit: decodes in ID, carries control through ID/EX, EX/MEM
// and MEM/WB, and owns the flags, branch resolution, load-use stall and forwarding.
module pipelined_control #(
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 3,
  parameter int FLAG_W  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [10:0]        id_opcode,
  input  logic [REG_W-1:0]   id_rn,
  input  logic [REG_W-1:0]   id_rm,
  input  logic [REG_W-1:0]   id_rd,
  input  logic               id_valid,
  input  logic [FLAG_W-1:0]  ex_flags,
  output logic [ALUOP_W+4:0] ex_ctrl,
  output logic [2:0]         mem_ctrl,
  output logic [1:0]         wb_ctrl,
  output logic [REG_W-1:0]   wb_rd,
  output logic               id_reg2loc,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               br_taken,
  output logic               uncond_br,
  output logic               stall,
  output logic               illegal_op,
  output logic [FLAG_W-1:0]  reg_flags
);

  localparam logic [REG_W-1:0] XZR = '1;
  localparam int SF = ALUOP_W;  // storeFlags position inside the EX bundle

  typedef enum logic [1:0] {BR_NONE, BR_B, BR_CBZ, BR_BLT} brType_e;

  typedef struct packed {
    logic memWrite;
    logic memRead;
    logic xferByte;
  } memCtl_t;

  typedef struct packed {
    logic regWrite;
    logic memToReg;
  } wbCtl_t;

  // exBits = {ALUSrc, ChooseImm, ChooseMovk, ChooseMovz, storeFlags, ALUOp}
  typedef struct packed {
    logic [ALUOP_W+4:0] exBits;
    memCtl_t            mem;
    wbCtl_t             wb;
    logic               illegal;
    brType_e            br;
  } exCtl_t;

  exCtl_t idCtl, exCtl;
  logic   idReg2loc;

  always_comb begin
    // NOTE: defaults first so every path assigns every bit: no latches, no x controls.
    idCtl     = '0;
    idReg2loc = 1'b0;
    casez (id_opcode)
      11'b000101?????: idCtl.br = BR_B;
      11'b10110100???: idCtl.br = BR_CBZ;
      11'b01010100???: idCtl.br = BR_BLT;
      11'b10101011000: begin
        idCtl.exBits      = {5'b00001, ALUOP_W'(2)};
        idCtl.wb.regWrite = 1'b1;
        idReg2loc         = 1'b1;
      end
      11'b11101011000: begin
        idCtl.exBits      = {5'b00001, ALUOP_W'(3)};
        idCtl.wb.regWrite = 1'b1;
        idReg2loc         = 1'b1;
      end
      11'b1001000100?: begin
        idCtl.exBits      = {5'b11000, ALUOP_W'(2)};
        idCtl.wb.regWrite = 1'b1;
      end
      11'b11111000010, 11'b00111000010: begin
        idCtl.exBits       = {5'b10000, ALUOP_W'(2)};
        idCtl.mem.memRead  = 1'b1;
        idCtl.mem.xferByte = ~id_opcode[10];
        idCtl.wb           = '{regWrite: 1'b1, memToReg: 1'b1};
      end
      11'b11111000000, 11'b00111000000: begin
        idCtl.exBits       = {5'b10000, ALUOP_W'(2)};
        idCtl.mem.memWrite = 1'b1;
        idCtl.mem.xferByte = ~id_opcode[10];
      end
      11'b111100101??: begin
        idCtl.exBits      = {5'b10100, ALUOP_W'(0)};
        idCtl.wb.regWrite = 1'b1;
      end
      11'b110100101??: begin
        idCtl.exBits      = {5'b10010, ALUOP_W'(0)};
        idCtl.wb.regWrite = 1'b1;
      end
      default: idCtl.illegal = 1'b1;
    endcase
  end

  logic             exValid, memValid, wbValid;
  logic [REG_W-1:0] exRd, exRn, exSecond, memRd, wbRd;
  memCtl_t          memCtl;
  wbCtl_t           memWb, wbCtl;
  logic [REG_W-1:0] idSecond;
  logic             loadUse, bubbleEx, memFwd, wbFwd;

  assign id_reg2loc = id_valid & idReg2loc;
  assign idSecond   = id_reg2loc ? id_rm : id_rd;

  always_comb begin
    br_taken = 1'b0;
    if (exValid) begin
      unique case (exCtl.br)
        BR_B:    br_taken = 1'b1;
        BR_CBZ:  br_taken = ex_flags[2];
        BR_BLT:  br_taken = reg_flags[3] ^ reg_flags[1];
        default: br_taken = 1'b0;
      endcase
    end
  end

  assign uncond_br = exValid & (exCtl.br == BR_B);
  assign loadUse   = exValid & exCtl.mem.memRead & (exRd != XZR) &
                     ((exRd == id_rn) | (exRd == idSecond));
  // A taken branch squashes the dependent instruction anyway, so it wins over the stall.
  assign stall     = loadUse & ~br_taken;
  assign bubbleEx  = stall | br_taken;

  // NOTE: state is updated with non-blocking assignments so every stage samples old values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exValid   <= 1'b0;
      exCtl     <= '0;
      exRd      <= '0;
      exRn      <= '0;
      exSecond  <= '0;
      memValid  <= 1'b0;
      memCtl    <= '0;
      memWb     <= '0;
      memRd     <= '0;
      wbValid   <= 1'b0;
      wbCtl     <= '0;
      wbRd      <= '0;
      reg_flags <= '0;
    end else begin
      if (bubbleEx || !id_valid) begin
        exValid <= 1'b0;
        exCtl   <= '0;
      end else begin
        exValid <= 1'b1;
        exCtl   <= idCtl;
      end
      exRd     <= id_rd;
      exRn     <= id_rn;
      exSecond <= idSecond;
      memValid <= exValid;
      memCtl   <= exCtl.mem;
      memWb    <= exCtl.wb;
      memRd    <= exRd;
      wbValid  <= memValid;
      wbCtl    <= memWb;
      wbRd     <= memRd;
      if (exValid && exCtl.exBits[SF]) reg_flags <= ex_flags;
    end
  end

  assign ex_ctrl    = exValid ? exCtl.exBits : '0;
  assign mem_ctrl   = memValid ? memCtl : '0;
  assign wb_ctrl    = wbValid ? wbCtl : '0;
  assign wb_rd      = wbValid ? wbRd : '0;
  assign illegal_op = exValid & exCtl.illegal;

  assign memFwd = memValid & memWb.regWrite & (memRd != XZR);
  assign wbFwd  = wbValid & wbCtl.regWrite & (wbRd != XZR);

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (memFwd && memRd == exRn)        fwd_a = 2'b10;
    else if (wbFwd && wbRd == exRn)     fwd_a = 2'b01;
    if (memFwd && memRd == exSecond)    fwd_b = 2'b10;
    else if (wbFwd && wbRd == exSecond) fwd_b = 2'b01;
  end

endmodule

// File: tb/tb_pipelined_control.sv
// Directed bench for pipelined_control: hand-computed control, hazard, forwarding,
// branch and reset expectations.
module tb_pipelined_control;

  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_BLT  = 11'b01010100000;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_ADDI = 11'b10010001000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_BAD  = 11'b11111111111;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] id_opcode = '0;
  logic [4:0]  id_rn = '0, id_rm = '0, id_rd = '0;
  logic        id_valid = 1'b0;
  logic [3:0]  ex_flags = '0;
  logic [7:0]  ex_ctrl;
  logic [2:0]  mem_ctrl;
  logic [1:0]  wb_ctrl;
  logic [4:0]  wb_rd;
  logic        id_reg2loc;
  logic [1:0]  fwd_a, fwd_b;
  logic        br_taken, uncond_br, stall, illegal_op;
  logic [3:0]  reg_flags;

  int numChecks = 0;
  int numPass   = 0;

  pipelined_control dut (
    .clk(clk), .reset_n(reset_n), .id_opcode(id_opcode), .id_rn(id_rn), .id_rm(id_rm),
    .id_rd(id_rd), .id_valid(id_valid), .ex_flags(ex_flags), .ex_ctrl(ex_ctrl),
    .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl), .wb_rd(wb_rd), .id_reg2loc(id_reg2loc),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .br_taken(br_taken), .uncond_br(uncond_br),
    .stall(stall), .illegal_op(illegal_op), .reg_flags(reg_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numChecks++;
    if (got === exp) numPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [10:0] op, input logic [4:0] rn, rm, rd);
    id_opcode = op;
    id_rn     = rn;
    id_rm     = rm;
    id_rd     = rd;
    id_valid  = 1'b1;
    #1;
  endtask

  task automatic nop();
    id_opcode = '0;
    id_rn     = '0;
    id_rm     = '0;
    id_rd     = '0;
    id_valid  = 1'b0;
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  initial begin
    #12;
    check("rst_ex_ctrl", ex_ctrl, 0);
    check("rst_mem_ctrl", mem_ctrl, 0);
    check("rst_wb_ctrl", wb_ctrl, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_flags", reg_flags, 0);
    check("rst_stall", stall, 0);
    check("rst_br", br_taken, 0);
    check("rst_illegal", illegal_op, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // ADDI X1 then LDUR X2,[X1]
    issue(OP_ADDI, 5'd0, 5'd0, 5'd1);
    tick();
    check("addi_fwd_a", fwd_a, 2'b00);
    issue(OP_LDUR, 5'd1, 5'd0, 5'd2);
    check("addi_ldur_stall", stall, 0);
    tick();
    check("ldur_fwd_a_exmem", fwd_a, 2'b10);
    check("ldur_ex_ctrl", ex_ctrl, 8'b1000_0010);
    nop();
    tick();
    check("ldur_mem_ctrl", mem_ctrl, 3'b010);
    tick();
    check("ldur_wb_ctrl", wb_ctrl, 2'b11);
    check("ldur_wb_rd", wb_rd, 5'd2);
    drain();

    // LDUR X3 then ADDS X4,X3,X5: one-cycle stall, then MEM/WB forward
    issue(OP_LDUR, 5'd5, 5'd0, 5'd3);
    tick();
    issue(OP_ADDS, 5'd3, 5'd5, 5'd4);
    check("lu_stall", stall, 1);
    check("adds_reg2loc", id_reg2loc, 1);
    tick();
    check("lu_stall_once", stall, 0);
    check("lu_bubble_ex", ex_ctrl, 0);
    tick();
    check("lu_fwd_a_memwb", fwd_a, 2'b01);
    check("lu_fwd_b", fwd_b, 2'b00);
    check("adds_ex_ctrl", ex_ctrl, 8'b0000_1010);
    ex_flags = 4'b0110;
    nop();
    tick();
    check("adds_flags", reg_flags, 4'b0110);
    ex_flags = 4'b1111;
    tick();
    check("bubble_no_flags", reg_flags, 4'b0110);
    ex_flags = 4'b0000;
    drain();

    // XZR is never a hazard or forwarding source
    issue(OP_LDUR, 5'd0, 5'd0, 5'd31);
    tick();
    issue(OP_ADDS, 5'd31, 5'd31, 5'd7);
    check("xzr_no_stall", stall, 0);
    drain();
    issue(OP_ADDI, 5'd0, 5'd0, 5'd31);
    tick();
    issue(OP_ADDI, 5'd31, 5'd0, 5'd8);
    tick();
    check("xzr_no_fwd", fwd_a, 2'b00);
    drain();

    // ADDI X9, gap, SUBS X6,X1,X9 (fwd_b from MEM/WB); SUBS N=1 then B.LT taken
    issue(OP_ADDI, 5'd0, 5'd0, 5'd9);
    tick();
    nop();
    tick();
    issue(OP_SUBS, 5'd1, 5'd9, 5'd6);
    tick();
    check("subs_fwd_b", fwd_b, 2'b01);
    check("subs_fwd_a", fwd_a, 2'b00);
    ex_flags = 4'b1000;
    issue(OP_BLT, 5'd0, 5'd0, 5'd0);
    check("subs_not_branch", br_taken, 0);
    tick();
    check("blt_flags", reg_flags, 4'b1000);
    check("blt_taken", br_taken, 1);
    check("blt_cond", uncond_br, 0);
    issue(OP_ADDI, 5'd0, 5'd0, 5'd11);
    tick();
    check("blt_squash", ex_ctrl, 0);
    drain();

    // SUBS with N=V=1 then B.LT not taken
    issue(OP_SUBS, 5'd1, 5'd2, 5'd6);
    tick();
    ex_flags = 4'b1010;
    issue(OP_BLT, 5'd0, 5'd0, 5'd0);
    tick();
    check("blt2_flags", reg_flags, 4'b1010);
    check("blt2_not_taken", br_taken, 0);
    ex_flags = 4'b0000;
    drain();

    // CBZ on Z, then B with a load-use pair behind it
    issue(OP_CBZ, 5'd0, 5'd0, 5'd12);
    tick();
    ex_flags = 4'b0100;
    #1;
    check("cbz_taken", br_taken, 1);
    check("cbz_cond", uncond_br, 0);
    ex_flags = 4'b0000;
    #1;
    check("cbz_not_taken", br_taken, 0);
    issue(OP_B, 5'd0, 5'd0, 5'd0);
    tick();
    check("b_taken", br_taken, 1);
    check("b_uncond", uncond_br, 1);
    issue(OP_LDUR, 5'd0, 5'd0, 5'd13);
    check("b_no_stall", stall, 0);
    tick();
    check("b_squash_ex", ex_ctrl, 0);
    issue(OP_ADDS, 5'd13, 5'd13, 5'd14);
    check("b_user_no_stall", stall, 0);
    nop();
    tick();
    check("b_squash_mem", mem_ctrl, 0);
    drain();

    // Unknown opcode
    issue(OP_BAD, 5'd0, 5'd0, 5'd3);
    tick();
    check("illegal_pulse", illegal_op, 1);
    check("illegal_ex_ctrl", ex_ctrl, 0);
    nop();
    tick();
    check("illegal_once", illegal_op, 0);
    check("illegal_mem", mem_ctrl, 0);
    tick();
    check("illegal_wb", wb_ctrl, 0);
    drain();

    // Reset mid-stream
    issue(OP_ADDS, 5'd1, 5'd2, 5'd14);
    tick();
    ex_flags = 4'b0101;
    issue(OP_LDUR, 5'd0, 5'd0, 5'd15);
    tick();
    check("pre_rst_ex", ex_ctrl, 8'b1000_0010);
    check("pre_rst_flags", reg_flags, 4'b0101);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_ex", ex_ctrl, 0);
    check("mid_rst_mem", mem_ctrl, 0);
    check("mid_rst_wb", wb_ctrl, 0);
    check("mid_rst_flags", reg_flags, 0);
    ex_flags = 4'b0000;
    @(negedge clk);
    reset_n = 1'b1;
    issue(OP_ADDS, 5'd1, 5'd2, 5'd14);
    tick();
    check("post_rst_ex", ex_ctrl, 8'b0000_1010);
    drain();

    $display("%0d/%0d checks passed", numPass, numChecks);
    $finish;
  end

endmodule
